// File: rtl/daq_pkg.sv
// Shared types and default timings for the ADC conversion scheduler.
// Timer width covers the largest BUSY timeout (TMO_BASE << OS_MAX).
package daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WBH,
    ST_WBL,
    ST_RDL,
    ST_PUSH,
    ST_RDH
  } state_e;

  localparam int NCH_MAX       = 8;
  localparam int CH_W          = 3;
  localparam int OS_MAX        = 6;
  localparam int PERIOD_W      = 16;
  localparam int TMR_W         = 17;
  localparam int CONVST_LO_DEF = 4;
  localparam int RD_LO_DEF     = 4;
  localparam int RD_HI_DEF     = 2;
  localparam int BUSY_RISE_DEF = 8;
  localparam int TMO_BASE_DEF  = 1000;

  function automatic logic [2:0] os_clamp(input logic [2:0] code);
    return (code > 3'(OS_MAX)) ? 3'(OS_MAX) : code;
  endfunction

endpackage

// File: rtl/daq_tick_gen.sv
// Sample-period counter: one-cycle tick each time the count wraps at period-1.
// Tick is decoded from the registered count; count held at zero while disabled.
module daq_tick_gen
  import daq_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] last;

  always_comb begin
    // Periods below 2 would tick every cycle and starve the FSM of idle time.
    last   = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : period_i - PERIOD_W'(1);
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q >= last) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/daq_conv_sched.sv
// ADC conversion scheduler: CONVST pulse, BUSY wait, per-channel CS/RD reads, valid/ready hand-off.
// All ADC strobes and sample outputs are registered; ready only gates state advance, never valid.
module daq_conv_sched
  import daq_pkg::*;
#(
  parameter int NCH       = NCH_MAX,
  parameter int DW        = 16,
  parameter int CONVST_LO = CONVST_LO_DEF,
  parameter int RD_LO     = RD_LO_DEF,
  parameter int RD_HI     = RD_HI_DEF,
  parameter int BUSY_RISE = BUSY_RISE_DEF,
  parameter int TMO_BASE  = TMO_BASE_DEF
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                en_i,
  input  logic [2:0]          os_sel_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [2:0]          adc_os_o,
  output logic                adc_convst_o,
  input  logic                adc_busy_i,
  output logic                adc_cs_no,
  output logic                adc_rd_no,
  input  logic [DW-1:0]       adc_db_i,
  output logic [DW-1:0]       smp_data_o,
  output logic [CH_W-1:0]     smp_ch_o,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  output logic                frame_o,
  output logic                overrun_o,
  output logic                timeout_o
);

  logic tick;

  daq_tick_gen u_tick (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  logic busy_s1_q, busy_s2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= adc_busy_i;
      busy_s2_q <= busy_s1_q;
    end
  end

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [2:0]        os_q, os_d;
  logic [DW-1:0]     data_q, data_d;
  logic              convst_q, convst_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              xfer, last_ch;
  logic [TMR_W-1:0]  tmo;

  assign xfer    = valid_q & smp_ready_i;
  assign last_ch = (ch_q == CH_W'(NCH - 1));
  assign tmo     = TMR_W'(TMO_BASE) << os_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ch_d      = ch_q;
    os_d      = os_q;
    data_d    = data_q;
    convst_d  = convst_q;
    cs_d      = cs_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        // OS pins only move between frames so a conversion never sees a ratio change.
        os_d = os_clamp(os_sel_i);
        if (tick && en_i) begin
          state_d  = ST_CONV;
          convst_d = 1'b0;
          tmr_d    = TMR_W'(CONVST_LO - 1);
        end
      end
      ST_CONV: begin
        if (tmr_q == '0) begin
          state_d  = ST_WBH;
          convst_d = 1'b1;
          tmr_d    = TMR_W'(BUSY_RISE - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WBH: begin
        if (busy_s2_q) begin
          state_d = ST_WBL;
          tmr_d   = tmo - TMR_W'(1);
        end else if (tmr_q == '0) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WBL: begin
        if (!busy_s2_q) begin
          state_d = ST_RDL;
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          tmr_d   = TMR_W'(RD_LO - 1);
        end else if (tmr_q == '0) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RDL: begin
        if (tmr_q == '0) begin
          state_d = ST_PUSH;
          data_d  = adc_db_i;
          rd_d    = 1'b1;
          valid_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_PUSH: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (last_ch) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            cs_d    = 1'b1;
          end else begin
            state_d = ST_RDH;
            ch_d    = ch_q + CH_W'(1);
            tmr_d   = TMR_W'(RD_HI - 1);
          end
        end
      end
      ST_RDH: begin
        if (tmr_q == '0) begin
          state_d = ST_RDL;
          rd_d    = 1'b0;
          tmr_d   = TMR_W'(RD_LO - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        convst_d = 1'b1;
        cs_d     = 1'b1;
        rd_d     = 1'b1;
        valid_d  = 1'b0;
      end
    endcase

    // A tick landing on the final handshake still counts: the FSM has not yet returned to idle.
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    if (!en_i) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      ch_q      <= '0;
      os_q      <= '0;
      data_q    <= '0;
      convst_q  <= 1'b1;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ch_q      <= ch_d;
      os_q      <= os_d;
      data_q    <= data_d;
      convst_q  <= convst_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign adc_os_o     = os_q;
  assign adc_convst_o = convst_q;
  assign adc_cs_no    = cs_q;
  assign adc_rd_no    = rd_q;
  assign smp_data_o   = data_q;
  assign smp_ch_o     = ch_q;
  assign smp_valid_o  = valid_q;
  assign frame_o      = xfer & (ch_q == '0);
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule
